// File: rtl/io_tx_pkg.sv
// Shared types for the CPU output-port UART transmitter: FSM state encoding and word/byte sizing.
package io_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/io_out_fifo.sv
// Synchronous word FIFO between the CPU capture strobe and the UART serialiser.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module io_out_fifo #(
    parameter int WIDTH      = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            pushData,
    input  logic                        pop,
    output logic [WIDTH-1:0]            popData,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic              doPush;
    logic              doPop;

    // Depth is a power of two, so the count MSB is set only when full.
    assign full    = count[ADDR_W];
    assign empty   = (count == '0);
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = mem[rdPtr];

    // NOTE: the storage array is not reset; pointers and count alone say which entries are valid.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_out_uart_tx.sv
// Captures CPU output words into a FIFO and sends each as WIDTH/8 bytes, MSB byte first, on a UART line.
// Define IO_TX_PARITY_EN for 8E1 framing (even parity bit after the data bits); default is 8N1.
module io_out_uart_tx
    import io_tx_pkg::*;
#(
    parameter int WIDTH        = 24,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        outFlagIOE,
    input  logic [WIDTH-1:0]            out,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int BYTES  = bytes_per_word(WIDTH);
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    if (WIDTH % 8 != 0 || WIDTH < 8) begin : gWidthCheck
        $error("io_out_uart_tx: WIDTH must be a non-zero multiple of 8");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gDepthCheck
        $error("io_out_uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (CLKS_PER_BIT < 2) begin : gBaudCheck
        $error("io_out_uart_tx: CLKS_PER_BIT must be at least 2");
    end

    tx_state_t         state;
    logic [BAUD_W-1:0] baudCnt;
    logic [2:0]        bitIdx;
    logic [BYTE_W-1:0] byteIdx;
    logic [WIDTH-1:0]  shiftWord;
    logic [7:0]        curByte;
    logic              baudDone;

    logic              fifoPop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [WIDTH-1:0]  fifoHead;
    logic              dropWord;

    io_out_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (outFlagIOE),
        .pushData (out),
        .pop      (fifoPop),
        .popData  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifo_count)
    );

    // LOAD is only entered with a non-empty FIFO, so this pop never underflows.
    assign fifoPop  = (state == LOAD);
    assign dropWord = outFlagIOE && fifoFull && !fifoPop;
    assign baudDone = (baudCnt == BAUD_LAST);
    // Sent bytes are shifted out of the top, so the current byte always sits in the MSBs.
    assign curByte  = shiftWord[WIDTH-1 -: 8];
    assign busy     = (fifo_count != '0) || (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (dropWord) begin
            overflow <= 1'b1;
        end
    end

    // NOTE: all state here uses non-blocking assignments, so every branch sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baudCnt   <= '0;
            bitIdx    <= '0;
            byteIdx   <= '0;
            shiftWord <= '0;
        end else begin
            // Transitions happen only on terminal count, so the wrap also clears it on entry.
            baudCnt <= baudDone ? '0 : baudCnt + 1'b1;
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    baudCnt <= '0;
                    if (!fifoEmpty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shiftWord <= fifoHead;
                    byteIdx   <= '0;
                    baudCnt   <= '0;
                    tx        <= 1'b0;
                    state     <= START;
                end
                START: begin
                    if (baudDone) begin
                        bitIdx <= '0;
                        tx     <= curByte[0];
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (baudDone) begin
                        if (bitIdx == 3'd7) begin
`ifdef IO_TX_PARITY_EN
                            tx    <= ^curByte;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bitIdx <= bitIdx + 3'd1;
                            tx     <= curByte[bitIdx + 3'd1];
                        end
                    end
                end
`ifdef IO_TX_PARITY_EN
                PARITY: begin
                    if (baudDone) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baudDone) begin
                        if (byteIdx != LAST_BYTE) begin
                            byteIdx   <= byteIdx + 1'b1;
                            shiftWord <= shiftWord << 8;
                            tx        <= 1'b0;
                            state     <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
